// File: rtl/i2c_slave_mc.sv
// Multi-address I2C slave bridging the pads to a per-channel register bus.
// Optional clock stretching on reads is enabled by I2C_SLAVE_MC_STRETCH_EN.
module i2c_slave_mc #(
    parameter int ADDR_BYTES     = 1,
    parameter int DATA_BYTES     = 2,
    parameter int NUM_ADDR       = 2,
    parameter int FILT_LEN       = 3,
    parameter int REG_ADDR_WIDTH = 8 * ADDR_BYTES,
    parameter int REG_DATA_WIDTH = 8 * DATA_BYTES,
    parameter int CH_W           = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sda_in,
    output logic                      sda_out,
    output logic                      sda_oen,
    input  logic                      scl_in,
    output logic                      scl_out,
    output logic                      scl_oen,
    input  logic [7*NUM_ADDR-1:0]     chip_addr,
    output logic [CH_W-1:0]           chan,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic                      wr_en,
    output logic [REG_DATA_WIDTH-1:0] wr_data,
    output logic                      rd_req,
    input  logic                      rd_valid,
    input  logic [REG_DATA_WIDTH-1:0] rd_data,
    output logic                      busy,
    output logic                      done
);

    localparam int FW = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, DEV_ADDR, ACK, REG_ADDR, WR_DATA, READ_FETCH, SEND, CHK_ACK
    } state_t;

    state_t                    state;
    logic [1:0]                sda_sync, scl_sync;
    logic [FW-1:0]             sda_cnt, scl_cnt;
    logic                      sda_f, scl_f, sda_d, scl_d;
    logic                      scl_rise, scl_fall, start, stop;
    logic [7*NUM_ADDR-1:0]     chip_q;
    logic [6:0]                shift;
    logic [7:0]                rx_byte;
    logic [2:0]                bit_cnt;
    logic [1:0]                abyte, dbyte;
    logic                      rw, ack_ph;
    logic [REG_DATA_WIDTH-1:0] wr_acc, word;
    logic                      hit;
    logic [CH_W-1:0]           hit_idx;
`ifdef I2C_SLAVE_MC_STRETCH_EN
    logic                      rel_pend;
`else
    logic                      unused_rd_valid;
    assign unused_rd_valid = rd_valid;
`endif

    assign scl_out  = 1'b0;
    assign rx_byte  = {shift, sda_f};
    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start    = scl_f & scl_d & sda_d & ~sda_f;
    assign stop     = scl_f & scl_d & ~sda_d & sda_f;

    // Synchronise and glitch-filter the pad inputs; register chip_addr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_sync <= 2'b11;
            scl_sync <= 2'b11;
            sda_cnt  <= '0;
            scl_cnt  <= '0;
            sda_f    <= 1'b1;
            scl_f    <= 1'b1;
            sda_d    <= 1'b1;
            scl_d    <= 1'b1;
            chip_q   <= '0;
        end else begin
            sda_sync <= {sda_sync[0], sda_in};
            scl_sync <= {scl_sync[0], scl_in};
            sda_d    <= sda_f;
            scl_d    <= scl_f;
            chip_q   <= chip_addr;
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FW'(FILT_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + FW'(1);
            end
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FW'(FILT_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + FW'(1);
            end
        end
    end

    // Lowest-index channel whose address matches the received byte.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--) begin
            if (chip_q[7*i +: 7] == rx_byte[7:1]) begin
                hit     = 1'b1;
                hit_idx = CH_W'(i);
            end
        end
    end

    // Protocol FSM; START/STOP override whatever the state would do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sda_out  <= 1'b1;
            sda_oen  <= 1'b1;
            scl_oen  <= 1'b1;
            chan     <= '0;
            reg_addr <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            abyte    <= '0;
            dbyte    <= '0;
            rw       <= 1'b0;
            ack_ph   <= 1'b0;
            wr_acc   <= '0;
            word     <= '0;
`ifdef I2C_SLAVE_MC_STRETCH_EN
            rel_pend <= 1'b0;
`endif
        end else begin
            wr_en  <= 1'b0;
            rd_req <= 1'b0;
            done   <= 1'b0;
            if (wr_en) reg_addr <= reg_addr + REG_ADDR_WIDTH'(1);
            unique case (state)
                IDLE: ;
                DEV_ADDR: if (scl_rise) begin
                    shift   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (hit) begin
                            chan   <= hit_idx;
                            busy   <= 1'b1;
                            rw     <= rx_byte[0];
                            ack_ph <= 1'b0;
                            state  <= ACK;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                REG_ADDR: if (scl_rise) begin
                    shift   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        reg_addr <= (reg_addr << 8) | REG_ADDR_WIDTH'(rx_byte);
                        abyte    <= abyte + 2'd1;
                        ack_ph   <= 1'b0;
                        state    <= ACK;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        wr_acc <= (wr_acc << 8) | REG_DATA_WIDTH'(rx_byte);
                        if (dbyte == 2'(DATA_BYTES - 1)) begin
                            wr_en   <= 1'b1;
                            wr_data <= (wr_acc << 8) | REG_DATA_WIDTH'(rx_byte);
                            dbyte   <= '0;
                        end else begin
                            dbyte <= dbyte + 2'd1;
                        end
                        ack_ph <= 1'b0;
                        state  <= ACK;
                    end
                end
                ACK: if (scl_fall) begin
                    if (!ack_ph) begin
                        sda_out <= 1'b0;
                        sda_oen <= 1'b0;
                        ack_ph  <= 1'b1;
                    end else begin
                        sda_out <= 1'b1;
                        sda_oen <= 1'b1;
                        ack_ph  <= 1'b0;
                        bit_cnt <= '0;
                        if (rw) begin
                            rd_req <= 1'b1;
                            state  <= READ_FETCH;
`ifdef I2C_SLAVE_MC_STRETCH_EN
                            scl_oen <= 1'b0;
`endif
                        end else if (abyte == 2'(ADDR_BYTES)) begin
                            state <= WR_DATA;
                        end else begin
                            state <= REG_ADDR;
                        end
                    end
                end
`ifdef I2C_SLAVE_MC_STRETCH_EN
                READ_FETCH: if (rd_valid) begin
                    word     <= rd_data;
                    sda_out  <= rd_data[REG_DATA_WIDTH-1];
                    sda_oen  <= rd_data[REG_DATA_WIDTH-1];
                    bit_cnt  <= '0;
                    rel_pend <= 1'b1;
                    state    <= SEND;
                end
`else
                READ_FETCH: if (!rd_req) begin
                    word    <= rd_data;
                    sda_out <= rd_data[REG_DATA_WIDTH-1];
                    sda_oen <= rd_data[REG_DATA_WIDTH-1];
                    bit_cnt <= '0;
                    state   <= SEND;
                end
`endif
                SEND: begin
`ifdef I2C_SLAVE_MC_STRETCH_EN
                    if (rel_pend) begin
                        scl_oen  <= 1'b1;
                        rel_pend <= 1'b0;
                    end
`endif
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_out <= 1'b1;
                            sda_oen <= 1'b1;
                            state   <= CHK_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            word    <= word << 1;
                            sda_out <= word[REG_DATA_WIDTH-2];
                            sda_oen <= word[REG_DATA_WIDTH-2];
                        end
                    end
                end
                CHK_ACK: begin
                    if (scl_rise && sda_f) begin
                        state <= IDLE;
                    end else if (scl_fall) begin
                        bit_cnt <= '0;
                        if (dbyte == 2'(DATA_BYTES - 1)) begin
                            dbyte    <= '0;
                            reg_addr <= reg_addr + REG_ADDR_WIDTH'(1);
                            rd_req   <= 1'b1;
                            state    <= READ_FETCH;
`ifdef I2C_SLAVE_MC_STRETCH_EN
                            scl_oen <= 1'b0;
`endif
                        end else begin
                            dbyte   <= dbyte + 2'd1;
                            word    <= word << 1;
                            sda_out <= word[REG_DATA_WIDTH-2];
                            sda_oen <= word[REG_DATA_WIDTH-2];
                            state   <= SEND;
                        end
                    end
                end
            endcase
            if (stop) begin
                state   <= IDLE;
                sda_out <= 1'b1;
                sda_oen <= 1'b1;
                scl_oen <= 1'b1;
                done    <= busy;
                busy    <= 1'b0;
`ifdef I2C_SLAVE_MC_STRETCH_EN
                rel_pend <= 1'b0;
`endif
            end
            if (start) begin
                state   <= DEV_ADDR;
                sda_out <= 1'b1;
                sda_oen <= 1'b1;
                scl_oen <= 1'b1;
                rd_req  <= 1'b0;
                bit_cnt <= '0;
                abyte   <= '0;
                dbyte   <= '0;
                ack_ph  <= 1'b0;
`ifdef I2C_SLAVE_MC_STRETCH_EN
                rel_pend <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_mc.sv
// Directed bench for i2c_slave_mc: bus-level master model and register-bus
// responder; honours I2C_SLAVE_MC_STRETCH_EN when the design is built with it.
module tb_i2c_slave_mc;

`ifdef I2C_SLAVE_MC_STRETCH_EN
    localparam int RD_LAT = 40;
`else
    localparam int RD_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sda_m, scl_m;
    logic        sda_out, sda_oen, scl_out, scl_oen;
    logic        sda_bus, scl_bus;
    logic [13:0] chip_addr;
    logic [0:0]  chan;
    logic [7:0]  reg_addr;
    logic        wr_en, rd_req, rd_valid, busy, done;
    logic [15:0] wr_data, rd_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt, rd_cnt, done_cnt, oen_low;
    int run, run_max;
    logic        rel_sda;
    logic [7:0]  wr_addr_l;
    logic [15:0] wr_data_l;
    logic [7:0]  rd_addr [0:3];
    int          lat;

    assign sda_bus = sda_m & (sda_oen | sda_out);
    assign scl_bus = scl_m & (scl_oen | scl_out);

    always #5 clk = ~clk;

    i2c_slave_mc #(
        .ADDR_BYTES(1), .DATA_BYTES(2), .NUM_ADDR(2), .FILT_LEN(3)
    ) dut (
        .clk(clk), .reset(reset),
        .sda_in(sda_bus), .sda_out(sda_out), .sda_oen(sda_oen),
        .scl_in(scl_bus), .scl_out(scl_out), .scl_oen(scl_oen),
        .chip_addr(chip_addr), .chan(chan), .reg_addr(reg_addr),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done)
    );

    // Register-file responder: data registered on rd_req, valid after RD_LAT.
    always @(posedge clk) begin
        rd_valid <= 1'b0;
        if (rd_req) begin
            rd_data <= (reg_addr == 8'hFF) ? 16'h1234 : 16'h5678;
            lat     <= RD_LAT;
        end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) rd_valid <= 1'b1;
        end
    end

    // Bus monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            wr_addr_l = reg_addr;
            wr_data_l = wr_data;
        end
        if (rd_req) begin
            if (rd_cnt < 4) rd_addr[rd_cnt] = reg_addr;
            rd_cnt++;
        end
        if (done) done_cnt++;
        if (!sda_oen) oen_low++;
        if (!scl_oen) begin
            run++;
        end else begin
            if (run > 0) begin
                if (run > run_max) run_max = run;
                rel_sda = sda_bus;
            end
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; oen_low = 0;
    endtask

    task automatic clock_bit(input logic b, input logic g, output logic r);
        int t;
        wcyc(8);
        sda_m = b;
        wcyc(8);
        scl_m = 1'b1;
        t = 0;
        while (!scl_bus && t < 2000) begin
            wcyc(1);
            t++;
        end
        if (!scl_bus) chk("scl_release", 32'(scl_bus), 32'd1);
        wcyc(4);
        if (g) begin
            sda_m = ~b;
            wcyc(1);
            sda_m = b;
        end
        wcyc(4);
        r = sda_bus;
        wcyc(8);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start;
        sda_m = 1'b0;
        wcyc(16);
        scl_m = 1'b0;
    endtask

    task automatic i2c_rstart;
        wcyc(8);
        sda_m = 1'b1;
        wcyc(8);
        scl_m = 1'b1;
        wcyc(16);
        sda_m = 1'b0;
        wcyc(16);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        wcyc(8);
        sda_m = 1'b0;
        wcyc(8);
        scl_m = 1'b1;
        wcyc(16);
        sda_m = 1'b1;
        wcyc(16);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic g,
                           inout int acks);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], g && (i == 7), r);
        clock_bit(1'b1, 1'b0, r);
        if (!r) acks++;
    endtask

    task automatic rd_byte(output logic [7:0] v, input logic nack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, r);
            v[i] = r;
        end
        clock_bit(nack, 1'b0, r);
    endtask

    initial begin
        int acks;
        logic [7:0] b0, b1, b2, b3;
        sda_m = 1'b1; scl_m = 1'b1;
        chip_addr = {7'h2A, 7'h50};
        reset = 1'b0;
        run = 0; run_max = 0; rel_sda = 1'b1; lat = 0;
        clr();
        wcyc(4);
        reset = 1'b1;
        wcyc(2);
        chk("rst_sda_oen", 32'(sda_oen), 32'd1);
        chk("rst_sda_out", 32'(sda_out), 32'd1);
        chk("rst_scl_oen", 32'(scl_oen), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_chan", 32'(chan), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        wcyc(10);

        // Write 0xBEEF to reg 0x10 of device 0x50.
        clr(); acks = 0;
        i2c_start();
        wr_byte(8'hA0, 1'b0, acks);
        wr_byte(8'h10, 1'b0, acks);
        wr_byte(8'hBE, 1'b0, acks);
        wr_byte(8'hEF, 1'b0, acks);
        chk("w_acks", 32'(acks), 32'd4);
        chk("w_chan", 32'(chan), 32'd0);
        chk("w_busy", 32'(busy), 32'd1);
        chk("w_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("w_wr_addr", 32'(wr_addr_l), 32'h10);
        chk("w_wr_data", 32'(wr_data_l), 32'hBEEF);
        chk("w_reg_inc", 32'(reg_addr), 32'h11);
        i2c_stop();
        chk("w_done", 32'(done_cnt), 32'd1);
        chk("w_busy_end", 32'(busy), 32'd0);

        // Unmatched address 0x33.
        clr(); acks = 0;
        i2c_start();
        wr_byte(8'h66, 1'b0, acks);
        wr_byte(8'h12, 1'b0, acks);
        wr_byte(8'h34, 1'b0, acks);
        chk("nm_busy", 32'(busy), 32'd0);
        i2c_stop();
        chk("nm_acks", 32'(acks), 32'd0);
        chk("nm_sda_driven", 32'(oen_low), 32'd0);
        chk("nm_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("nm_done", 32'(done_cnt), 32'd0);

        // Reg 0xFF on 0x2A, repeated START, read two words.
        clr(); acks = 0; run_max = 0;
        i2c_start();
        wr_byte(8'h54, 1'b0, acks);
        wr_byte(8'hFF, 1'b0, acks);
        i2c_rstart();
        wr_byte(8'h55, 1'b0, acks);
        rd_byte(b0, 1'b0);
        rd_byte(b1, 1'b0);
        rd_byte(b2, 1'b0);
        rd_byte(b3, 1'b1);
        i2c_stop();
        chk("r_acks", 32'(acks), 32'd3);
        chk("r_chan", 32'(chan), 32'd1);
        chk("r_rd_cnt", 32'(rd_cnt), 32'd2);
        chk("r_rd_addr0", 32'(rd_addr[0]), 32'hFF);
        chk("r_rd_addr1", 32'(rd_addr[1]), 32'h00);
        chk("r_bytes", {b0, b1, b2, b3}, 32'h12345678);
        chk("r_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("r_done", 32'(done_cnt), 32'd1);
`ifdef I2C_SLAVE_MC_STRETCH_EN
        chk("st_len_ge40", 32'(run_max >= 40), 32'd1);
        chk("st_first_bit", 32'(rel_sda), 32'd0);
`else
        chk("no_stretch", 32'(run_max), 32'd0);
`endif

        // Partial word then STOP.
        clr(); acks = 0;
        i2c_start();
        wr_byte(8'hA0, 1'b0, acks);
        wr_byte(8'h20, 1'b0, acks);
        wr_byte(8'hAA, 1'b0, acks);
        i2c_stop();
        chk("p_acks", 32'(acks), 32'd3);
        chk("p_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("p_reg_addr", 32'(reg_addr), 32'h20);

        // One-cycle SDA glitches while SCL high must not act as STOP/START.
        clr(); acks = 0;
        i2c_start();
        wr_byte(8'hA0, 1'b0, acks);
        wr_byte(8'h30, 1'b0, acks);
        wr_byte(8'h00, 1'b1, acks);
        wr_byte(8'hFF, 1'b1, acks);
        chk("g_acks", 32'(acks), 32'd4);
        chk("g_busy", 32'(busy), 32'd1);
        chk("g_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("g_wr_addr", 32'(wr_addr_l), 32'h30);
        chk("g_wr_data", 32'(wr_data_l), 32'h00FF);
        i2c_stop();
        chk("g_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
